// File: rtl/snes_pad_reader.sv
// snes_pad_reader: polls an SNES pad and publishes its buttons as active-low six-button levels.
// Ports: clk, rst_n (async, active low); pad_data (serial pad data, low = pressed, async);
//   pad_latch / pad_clk drive the pad; up, dw, lf, rg, a, b, c, st, x, y, z, md, hm are
//   registered active-low button levels; frame_stb pulses for one cycle per published frame;
//   pad_err is high while the most recent frame failed its ID check.
// Option: define SNES_PAD_DEBOUNCE_EN to publish a frame only when its 12 button bits match
//   the previous accepted frame.
module snes_pad_reader #(
  parameter int HALF = 60,
  parameter int POLL_PERIOD = 166000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_data,
  output logic pad_latch,
  output logic pad_clk,
  output logic up,
  output logic dw,
  output logic lf,
  output logic rg,
  output logic a,
  output logic b,
  output logic c,
  output logic st,
  output logic x,
  output logic y,
  output logic z,
  output logic md,
  output logic hm,
  output logic frame_stb,
  output logic pad_err
);
  typedef enum logic [1:0] {IDLE, LATCH, SHIFT, UPDATE} state_t;
  localparam logic [17:0] H1 = 18'(HALF - 1);
  localparam logic [17:0] H2 = 18'(2 * HALF - 1);
  localparam logic [17:0] P1 = 18'(POLL_PERIOD - 1);
  state_t state;
  logic [17:0] cnt;
  logic [3:0] idx;
  logic [15:0] sr;
  logic s1, s2, ok, pub, hm_n;
  logic [12:0] btn, nxt;
  assign {up, dw, lf, rg, a, b, c, st, x, y, z, md, hm} = btn;
  // sr bit i holds serial bit i: B Y Sel St Up Dn Lf Rt A X L R, then ID[15:12]
  assign ok = &sr[15:12];
  // Select+Start together is the home chord; it masks both buttons
  assign hm_n = sr[2] | sr[3];
  assign nxt = {sr[4], sr[5], sr[6], sr[7], sr[1], sr[0], sr[8], sr[3] | ~hm_n,
                sr[10], sr[9], sr[11], sr[2] | ~hm_n, hm_n};
`ifdef SNES_PAD_DEBOUNCE_EN
  logic [11:0] cand;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cand <= '1;
    else if (state == SHIFT && cnt == H2 && idx == 4'd15 && ok) cand <= sr[11:0];
  assign pub = ok && sr[11:0] == cand;
`else
  assign pub = ok;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sr <= '1;
      s1 <= 1'b1;
      s2 <= 1'b1;
      pad_latch <= 1'b0;
      pad_clk <= 1'b1;
      btn <= '1;
      frame_stb <= 1'b0;
      pad_err <= 1'b0;
    end else begin
      s1 <= pad_data;
      s2 <= s1;
      frame_stb <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= (cnt == P1) ? '0 : cnt + 18'd1;
          if (cnt == P1) begin
            state <= LATCH;
            pad_latch <= 1'b1;
          end
        end
        LATCH: begin
          cnt <= (cnt == H2) ? '0 : cnt + 18'd1;
          idx <= '0;
          if (cnt == H2) begin
            state <= SHIFT;
            pad_latch <= 1'b0;
          end
        end
        SHIFT: begin
          cnt <= (cnt == H2) ? '0 : cnt + 18'd1;
          // sample at the end of the high half, just before pad_clk falls
          if (cnt == H1) begin
            pad_clk <= 1'b0;
            sr[idx] <= s2;
          end
          if (cnt == H2) begin
            pad_clk <= 1'b1;
            idx <= idx + 4'd1;
            if (idx == 4'd15) begin
              // outputs are registered here so they are valid throughout UPDATE
              state <= UPDATE;
              frame_stb <= pub;
              pad_err <= !ok;
              if (pub) btn <= nxt;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_snes_pad_reader.sv
// tb_snes_pad_reader: table-driven and randomized checks of snes_pad_reader against a frame-level model.
module tb_snes_pad_reader;
  localparam int HALF = 4;
  localparam int POLL = 20;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pad_data;
  logic pad_latch, pad_clk, frame_stb, pad_err;
  logic up, dw, lf, rg, a, b, c, st, x, y, z, md, hm;
  logic [12:0] btn;
  assign btn = {up, dw, lf, rg, a, b, c, st, x, y, z, md, hm};
  snes_pad_reader #(.HALF(HALF), .POLL_PERIOD(POLL)) dut (
    .clk(clk), .rst_n(rst_n), .pad_data(pad_data), .pad_latch(pad_latch), .pad_clk(pad_clk),
    .up(up), .dw(dw), .lf(lf), .rg(rg), .a(a), .b(b), .c(c), .st(st), .x(x), .y(y), .z(z),
    .md(md), .hm(hm), .frame_stb(frame_stb), .pad_err(pad_err)
  );
  always #5 clk = ~clk;
  // pad model: latch reloads, each rising pad_clk shifts out the next bit
  logic [15:0] word = 16'hFFFF;
  int pidx = 0;
  always @(posedge pad_latch or posedge pad_clk) pidx <= pad_latch ? 0 : pidx + 1;
  always_comb pad_data = (pidx < 16) ? word[pidx[3:0]] : 1'b0;
  int stb_cnt = 0;
  always @(negedge clk) if (frame_stb) stb_cnt <= stb_cnt + 1;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask
  // frame-level reference model; serial bit order B Y Sel St Up Dn Lf Rt A X L R ID*4
  localparam int B_ = 0, Y_ = 1, SE = 2, ST = 3, UP = 4, DN = 5, LF = 6, RT = 7;
  localparam int A_ = 8, X_ = 9, L_ = 10, R_ = 11;
  logic [12:0] m_btn;
  logic m_err, m_stb;
  logic [11:0] m_cand;
  function automatic logic [12:0] decode(input logic [15:0] w);
    logic home;
    home = !w[SE] && !w[ST];
    return {w[UP], w[DN], w[LF], w[RT], w[Y_], w[B_], w[A_], home ? 1'b1 : w[ST],
            w[L_], w[X_], w[R_], home ? 1'b1 : w[SE], !home};
  endfunction
  task automatic model_reset();
    m_btn = '1;
    m_err = 1'b0;
    m_stb = 1'b0;
    m_cand = '1;
  endtask
  task automatic model_step(input logic [15:0] w);
    m_stb = 1'b0;
    if (w[15:12] != 4'hF) m_err = 1'b1;
    else begin
      m_err = 1'b0;
`ifdef SNES_PAD_DEBOUNCE_EN
      if (w[11:0] == m_cand) begin
        m_btn = decode(w);
        m_stb = 1'b1;
      end
      m_cand = w[11:0];
`else
      m_btn = decode(w);
      m_stb = 1'b1;
`endif
    end
  endtask
  task automatic wait_latch(output int n);
    n = 0;
    while (!pad_latch && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL latch_timeout got %0d expected <400", n);
    end
  endtask
  logic [12:0] g_btn;
  logic g_stb, g_err;
  int g_pulses;
  task automatic run(input logic [15:0] w);
    int n, s0;
    model_step(w);
    word = w;
    s0 = stb_cnt;
    wait_latch(n);
    repeat (34 * HALF) @(posedge clk);
    @(negedge clk);
    g_btn = btn;
    g_stb = frame_stb;
    g_err = pad_err;
    @(negedge clk);
    #1;
    g_pulses = stb_cnt - s0;
  endtask
  typedef struct {
    logic [11:0] prs;
    logic [3:0] id;
    logic [12:0] exp;
    logic stb;
    logic err;
  } vec_t;
  vec_t tab[8];
  initial begin
    int n, lat, low, pulses, stbs, stb_fc;
    logic pc_prev;
    logic [15:0] w;
    tab[0] = '{12'h111, 4'hF, 13'b0111100111111, 1'b1, 1'b0};
    tab[1] = '{12'h00C, 4'hF, 13'b1111111111110, 1'b1, 1'b0};
    tab[2] = '{12'h008, 4'hF, 13'b1111111011111, 1'b1, 1'b0};
    tab[3] = '{12'hFFF, 4'h0, 13'b1111111011111, 1'b0, 1'b1};
    tab[4] = '{12'h602, 4'hF, 13'b1111011100111, 1'b1, 1'b0};
    tab[5] = '{12'h0F0, 4'hF, 13'b0000111111111, 1'b1, 1'b0};
    tab[6] = '{12'h001, 4'h7, 13'b0000111111111, 1'b0, 1'b1};
    tab[7] = '{12'h804, 4'hF, 13'b1111111111001, 1'b1, 1'b0};
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_latch", pad_latch, 0);
    chk("rst_padclk", pad_clk, 1);
    chk("rst_btn", btn, 13'h1FFF);
    chk("rst_stb", frame_stb, 0);
    chk("rst_err", pad_err, 0);
    model_reset();
    rst_n = 1'b1;
    wait_latch(n);
    chk("first_latch_cycle", n, POLL);
    lat = 0; low = 0; pulses = 0; stbs = 0; stb_fc = 0; pc_prev = 1'b1;
    for (int fc = 1; fc <= 140; fc++) begin
      lat += int'(pad_latch);
      if (!pad_clk) low++;
      if (!pad_clk && pc_prev) pulses++;
      pc_prev = pad_clk;
      if (frame_stb) begin
        stbs++;
        stb_fc = fc;
      end
      @(posedge clk);
      #1;
    end
    model_step(word);
    chk("latch_len", lat, 2 * HALF);
    chk("clk_pulses", pulses, 16);
    chk("clk_low_cycles", low, 16 * HALF);
    chk("stb_frame_cycle", stb_fc, 34 * HALF + 1);
    chk("stb_count", stbs, 1);
    for (int i = 0; i < 8; i++) begin
      w = {tab[i].id, ~tab[i].prs};
      run(w);
      run(w);
      chk($sformatf("tab%0d_btn", i), g_btn, tab[i].exp);
      chk($sformatf("tab%0d_stb", i), g_stb, tab[i].stb);
      chk($sformatf("tab%0d_err", i), g_err, tab[i].err);
      chk($sformatf("tab%0d_pulses", i), g_pulses, tab[i].stb);
    end
    run(16'hFFFF);
    run(16'hFFFF);
`ifdef SNES_PAD_DEBOUNCE_EN
    run(16'hFFFE);
    chk("db_f1_b", b, 1);
    chk("db_f1_stb", g_stb, 0);
    run(16'hFFFF);
    chk("db_f2_b", b, 1);
    chk("db_f2_stb", g_stb, 0);
    run(16'hFFFF);
    chk("db_f3_b", b, 1);
    chk("db_f3_stb", g_stb, 1);
    run(16'hFFFE);
    chk("db_p1_b", b, 1);
    chk("db_p1_stb", g_stb, 0);
    run(16'hFFFE);
    chk("db_p2_b", b, 0);
    chk("db_p2_stb", g_stb, 1);
`else
    run(16'hFFFE);
    chk("nodb_press_b", b, 0);
    chk("nodb_press_stb", g_stb, 1);
    run(16'hFFFF);
    chk("nodb_rel_b", b, 1);
    chk("nodb_rel_stb", g_stb, 1);
`endif
    run(16'hFFFE);
    run(16'hFFFE);
    chk("pre_abort_b", b, 0);
    n = stb_cnt;
    wait_latch(lat);
    repeat (8 * HALF + 4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_padclk", pad_clk, 1);
    chk("abort_latch", pad_latch, 0);
    chk("abort_btn", btn, 13'h1FFF);
    chk("abort_err", pad_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    wait_latch(lat);
    chk("abort_restart_cycle", lat, POLL);
    chk("abort_no_stb", stb_cnt - n, 0);
    repeat (34 * HALF + 3) @(posedge clk);
    model_step(word);
    chk("abort_next_btn", btn, m_btn);
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        w[11:0] = 12'($urandom);
        w[15:12] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      end
      run(w);
      chk($sformatf("rnd%0d_btn", i), g_btn, m_btn);
      chk($sformatf("rnd%0d_stb", i), g_stb, m_stb);
      chk($sformatf("rnd%0d_err", i), g_err, m_err);
      chk($sformatf("rnd%0d_pulses", i), g_pulses, m_stb);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
